// File: rtl/fir_s2p_packer.sv
`default_nettype none
// ============================================================================
//  Module   : fir_s2p_packer
//  Function : Serial-to-parallel packer feeding the 2-parallel FIR. It pairs
//             even/odd samples and zero-pads the last pair of odd frames.
//  Revision : 1.0  initial release
// ============================================================================
module fir_s2p_packer #(
    parameter int DATA_W    = 14,
    parameter int FRAME_LEN = 129,
    parameter int CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic                     ValidIn,
    input  logic signed [DATA_W-1:0] FilterIn,
    input  logic                     LastIn,
    output logic                     ValidOut,
    output logic signed [DATA_W-1:0] FilterOut1,
    output logic signed [DATA_W-1:0] FilterOut2,
    output logic                     LastOut,
    output logic                     PadOut,
    output logic [CNT_W-1:0]         SampleCnt
);

    typedef enum logic [0:0] {
        ST_EVEN = 1'b0,
        ST_ODD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_t                     state_q, state_d;
    logic signed [DATA_W-1:0]   even_q,  even_d;
    logic [CNT_W-1:0]           cnt_q,   cnt_d;
    logic                       valid_q, valid_d;
    logic signed [DATA_W-1:0]   out1_q,  out1_d;
    logic signed [DATA_W-1:0]   out2_q,  out2_d;
    logic                       last_q,  last_d;
    logic                       pad_q,   pad_d;
    logic                       w_frame_end;

    // The accepted sample closes the frame if flagged, or if it is the
    // FRAME_LEN-th one (covers a missing LastIn).
    assign w_frame_end = LastIn || (cnt_q == C_LAST_IDX);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EVEN;
            even_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            out1_q  <= '0;
            out2_q  <= '0;
            last_q  <= 1'b0;
            pad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            even_q  <= even_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            out1_q  <= out1_d;
            out2_q  <= out2_d;
            last_q  <= last_d;
            pad_q   <= pad_d;
        end
    end

    always_comb begin
        state_d = state_q;
        even_d  = even_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        out1_d  = out1_q;
        out2_d  = out2_q;
        last_d  = 1'b0;
        pad_d   = 1'b0;

        if (ValidIn) begin
            case (state_q)
                ST_EVEN: begin
                    even_d = FilterIn;
                    if (w_frame_end) begin
                        valid_d = 1'b1;
                        out1_d  = FilterIn;
                        out2_d  = '0;
                        last_d  = 1'b1;
                        pad_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_ODD;
                    end
                end
                ST_ODD: begin
                    valid_d = 1'b1;
                    out1_d  = even_q;
                    out2_d  = FilterIn;
                    last_d  = w_frame_end;
                    cnt_d   = w_frame_end ? '0 : cnt_q + 1'b1;
                    state_d = ST_EVEN;
                end
                default: begin
                    state_d = ST_EVEN;
                end
            endcase
        end
    end

    assign ValidOut   = valid_q;
    assign FilterOut1 = out1_q;
    assign FilterOut2 = out2_q;
    assign LastOut    = last_q;
    assign PadOut     = pad_q;
    assign SampleCnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_s2p_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_s2p_packer
//  Function : Self-checking bench for fir_s2p_packer against a queue-based
//             frame/pair reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fir_s2p_packer;

    localparam int DATA_W    = 14;
    localparam int FRAME_LEN = 129;
    localparam int CNT_W     = 8;

    logic                     clk = 1'b0;
    logic                     i_rst_n;
    logic                     ValidIn;
    logic signed [DATA_W-1:0] FilterIn;
    logic                     LastIn;
    logic                     ValidOut;
    logic signed [DATA_W-1:0] FilterOut1;
    logic signed [DATA_W-1:0] FilterOut2;
    logic                     LastOut;
    logic                     PadOut;
    logic [CNT_W-1:0]         SampleCnt;

    fir_s2p_packer #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .ValidIn    (ValidIn),
        .FilterIn   (FilterIn),
        .LastIn     (LastIn),
        .ValidOut   (ValidOut),
        .FilterOut1 (FilterOut1),
        .FilterOut2 (FilterOut2),
        .LastOut    (LastOut),
        .PadOut     (PadOut),
        .SampleCnt  (SampleCnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Reference model: samples of the current frame not yet emitted,
    // plus the expected output pair.
    logic [DATA_W-1:0] pend[$];
    int                m_n;
    bit                m_valid, m_last, m_pad;
    logic [DATA_W-1:0] m_o1, m_o2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_n = 0; m_valid = 0; m_last = 0; m_pad = 0; m_o1 = '0; m_o2 = '0;
    endtask

    task automatic model_accept(input bit v, input logic [DATA_W-1:0] d, input bit l);
        bit fe;
        m_valid = 0; m_last = 0; m_pad = 0;
        if (v) begin
            m_n++;
            fe = l || (m_n == FRAME_LEN);
            pend.push_back(d);
            if (pend.size() == 2) begin
                m_valid = 1; m_o1 = pend[0]; m_o2 = pend[1]; m_last = fe; m_pad = 0;
                pend.delete();
            end else if (fe) begin
                m_valid = 1; m_o1 = pend[0]; m_o2 = '0; m_last = 1; m_pad = 1;
                pend.delete();
            end
            if (fe) m_n = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, {31'd0, ValidOut}, {31'd0, m_valid});
        chk({tag, ".out1"},  {18'd0, FilterOut1}, {18'd0, m_o1});
        chk({tag, ".out2"},  {18'd0, FilterOut2}, {18'd0, m_o2});
        chk({tag, ".last"},  {31'd0, LastOut}, {31'd0, m_last});
        chk({tag, ".pad"},   {31'd0, PadOut}, {31'd0, m_pad});
        chk({tag, ".cnt"},   {24'd0, SampleCnt}, 32'(m_n));
        if (ValidOut) pulses++;
    endtask

    task automatic step(input string tag, input bit v, input logic [DATA_W-1:0] d, input bit l);
        ValidIn  = v;
        FilterIn = d;
        LastIn   = l;
        @(posedge clk);
        #1;
        model_accept(v, d, l);
        check_outputs(tag);
        ValidIn = 1'b0;
        LastIn  = 1'b0;
    endtask

    initial begin
        ValidIn  = 1'b0;
        FilterIn = '0;
        LastIn   = 1'b0;
        i_rst_n  = 1'b0;
        model_reset();
        #12;
        check_outputs("reset");
        @(posedge clk); #1;
        i_rst_n = 1'b1;

        // Four samples, LastIn on the fourth
        step("t1", 1, 14'd1, 0);
        step("t1", 1, 14'd2, 0);
        step("t1", 1, 14'd3, 0);
        step("t1", 1, 14'd4, 1);
        step("t1idle", 0, 14'd0, 0);

        // Full frame without LastIn: auto end at the 129th sample
        pulses = 0;
        for (int i = 0; i < FRAME_LEN; i++) step("frame", 1, 14'(i), 0);
        chk("frame.pulses", 32'(pulses), 32'd65);

        // Extreme values across an idle gap
        step("ext", 1, 14'h2000, 0);
        for (int i = 0; i < 3; i++) step("gap", 0, 14'h1555, 0);
        step("ext", 1, 14'h1FFF, 0);

        // Close the open frame, then single padded sample and re-pairing
        step("close", 1, 14'd0, 1);
        step("single", 1, 14'd5, 1);
        step("after", 1, 14'd6, 0);
        step("after", 1, 14'd7, 0);

        // Mid-cycle async reset while a sample is held in ODD
        step("prerst", 1, 14'd20, 0);
        step("prerst", 1, 14'd21, 0);
        step("held", 1, 14'd7, 0);
        #3;
        i_rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("asyncrst");
        @(posedge clk); #2;
        i_rst_n = 1'b1;
        step("postrst", 1, 14'd9, 0);
        step("postrst", 1, 14'd10, 0);

        // Frame A (3 samples) then frame B (2 samples) back-to-back
        step("fa", 1, 14'd100, 0);
        step("fa", 1, 14'd101, 0);
        step("fa", 1, 14'd102, 1);
        step("fb", 1, 14'd200, 0);
        step("fb", 1, 14'd201, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step("rand", ($urandom_range(0, 9) < 7), 14'($urandom),
                 ($urandom_range(0, 19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_s2p_packer.md
Name: fir_s2p_packer

Overview:
- Upstream feeder for the 2-parallel FIR build: turns a serial sample stream (one 14-bit sample per clock, at most) into even/odd pairs x[2k], x[2k+1] on FilterIn1/FilterIn2, each pair marked by a one-cycle valid.
- Tracks frame boundaries. Odd-length frames (129 samples) get a zero-padded final pair with a pad flag, so the downstream writer drops the dummy y[2k+1].

Parameters:
- DATA_W, 14, sample width (two's complement).
- FRAME_LEN, 129, samples per frame; forces end-of-frame if LastIn never arrives.
- CNT_W, 8, sample counter width; must satisfy 2^CNT_W > FRAME_LEN.

Ports:
- clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- ValidIn  in  1  FilterIn carries a sample this cycle.
- FilterIn  in  DATA_W  serial sample, signed.
- LastIn  in  1  qualifies the final sample of a frame; ignored unless ValidIn=1.
- ValidOut  out  1  one-cycle pulse: FilterOut1/FilterOut2 carry a pair.
- FilterOut1  out  DATA_W  even sample x[2k].
- FilterOut2  out  DATA_W  odd sample x[2k+1]; 0 when padded.
- LastOut  out  1  pair is the frame's last; valid with ValidOut.
- PadOut  out  1  FilterOut2 is padding; valid with ValidOut.
- SampleCnt  out  CNT_W  samples accepted in the current frame.

Behaviour:
- Reset (async assert, sync release): state=EVEN, ValidOut=0, FilterOut1=0, FilterOut2=0, LastOut=0, PadOut=0, SampleCnt=0. The held even sample is discarded.
- The state machine has two states, EVEN and ODD.
- EVEN, ValidIn=1: latch FilterIn into the even register. SampleCnt+1.
  - If frame_end: next cycle drive ValidOut=1, FilterOut1=latched sample, FilterOut2=0, PadOut=1, LastOut=1. Stay EVEN. SampleCnt becomes 0.
  - Otherwise go to ODD.
- ODD, ValidIn=1: next cycle drive ValidOut=1, FilterOut1=even register, FilterOut2=FilterIn, PadOut=0, LastOut=frame_end. Go to EVEN. SampleCnt+1, or 0 if frame_end.
- ValidIn=0 in either state: no state change, ValidOut=0, held sample kept indefinitely. Gaps of any length are allowed.
- frame_end = LastIn OR (SampleCnt == FRAME_LEN-1), i.e. the accepted sample is the FRAME_LEN-th. LastIn on any earlier sample ends the frame early.
- Latency: the pair appears exactly 1 cycle after the clock edge that accepts its second sample, or its only sample when padded. All outputs are registered.
- ValidOut, LastOut and PadOut are single-cycle pulses, 0 when ValidOut=0. FilterOut1 and FilterOut2 hold their last pair value between pulses.
- Throughput: at most one pair every 2 cycles, except a padded pair may follow the previous pair on consecutive cycles. There is no backpressure; the downstream FIR always accepts.
- Back-to-back frames: the sample after a frame_end sample starts a new frame in EVEN with SampleCnt=0. No idle cycle is required.
- No arithmetic is performed. Samples pass bit-exact, with sign preserved.

Test Plan:
- Reset, then samples 1,2,3,4 on consecutive cycles with LastIn on 4 -> pairs (1,2) and (3,4) one cycle after samples 2 and 4; only the second has LastOut=1; PadOut=0 on both; SampleCnt=0 afterwards.
- 129-sample frame, values 0..128, no LastIn -> 65 ValidOut pulses; pair 64 = (128,0) with PadOut=1 and LastOut=1; auto frame_end fires at sample 129.
- Sample -8192 (0x2000), then 3 idle cycles, then 8191 -> single pair (-8192, 8191) one cycle after the 8191 accept; ValidOut stays 0 during the gap.
- Single sample 5 with LastIn=1 -> next cycle (5,0) with PadOut=1 and LastOut=1; state remains EVEN; the next sample 6 is treated as even.
- Assert i_rst_n=0 mid-clock while sample 7 is held in ODD -> outputs clear immediately without waiting for a clock edge; after release, samples 9,10 -> pair (9,10); sample 7 never appears.
- Frame A: 3 samples with LastIn on 3. Frame B: 2 samples, immediately following, with LastIn on 2 -> pairs (a0,a1), (a2,0 pad/last), (b0,b1 last).
